// File: rtl/residual_add_ln_prep_pkg.sv
// residual_add_ln_prep_pkg
//   Shared definitions for the residual-add / layer-norm prep stage:
//   default arithmetic parameters, the stage-0 payload type and the
//   saturating narrowing helper used on the output side.
package residual_add_ln_prep_pkg;

    localparam int D_W_DEF          = 8;
    localparam int D_W_ACC_DEF      = 32;
    localparam int LN_BITS_DEF      = 22;
    localparam int ACC_SHIFT_DEF    = 8;
    localparam int RES_SHIFT_DEF    = 6;
    localparam int MATRIXSIZE_W_DEF = 24;

    // Both stage-0 operands live in D_W_ACC+1 bits: the rounded accumulator
    // needs the extra bit for the rounding add, the shifted residual fits.
    localparam int PAY_W = D_W_ACC_DEF + 1;

    typedef struct packed {
        logic signed [PAY_W-1:0] a;    // rounded, shifted accumulator
        logic signed [PAY_W-1:0] r;    // shifted residual
        logic                    lin;  // acc_tlast carried for framing check
    } s0_pay_t;

    // Clamp a sign-extended D_W_ACC+2-bit sum to the signed LN_BITS range.
    // The caller narrows the return value to ln_bits.
    function automatic logic signed [63:0] sat_to_ln(input logic signed [63:0] s,
                                                     input int                 ln_bits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ln_bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ln_bits - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/residual_add_ln_prep_if.sv
// residual_add_ln_prep_if
//   Stream bundle for residual_add_ln_prep.
//   acc_* : 32-bit accumulator stream (with tlast) into the block
//   res_* : 8-bit residual stream into the block
//   qout_*: LN_BITS saturated sum stream out to layer-norm
//   slave  = the block's view, master = the upstream/downstream side.
interface residual_add_ln_prep_if
    import residual_add_ln_prep_pkg::*;
#(
    parameter int D_W     = D_W_DEF,
    parameter int D_W_ACC = D_W_ACC_DEF,
    parameter int LN_BITS = LN_BITS_DEF
);
    logic [D_W_ACC-1:0] acc_tdata;
    logic               acc_tlast;
    logic               acc_tvalid;
    logic               acc_tready;
    logic [D_W-1:0]     res_tdata;
    logic               res_tvalid;
    logic               res_tready;
    logic [LN_BITS-1:0] qout_tdata;
    logic               qout_tlast;
    logic               qout_tvalid;
    logic               qout_tready;

    modport slave (
        input  acc_tdata, acc_tlast, acc_tvalid, res_tdata, res_tvalid, qout_tready,
        output acc_tready, res_tready, qout_tdata, qout_tlast, qout_tvalid
    );

    modport master (
        output acc_tdata, acc_tlast, acc_tvalid, res_tdata, res_tvalid, qout_tready,
        input  acc_tready, res_tready, qout_tdata, qout_tlast, qout_tvalid
    );
endinterface

// File: rtl/residual_add_ln_prep_matrix_pos_counter.sv
// matrix_pos_counter
//   Row/column position tracker for a DIM1 x DIM2 element stream.
//   clk, rst   : clock, async active-high reset
//   step_i     : advance one element (output handshake)
//   dim1_i/2_i : live matrix dimensions (rows, row length)
//   end_o      : current position is the last element of the matrix
module matrix_pos_counter #(
    parameter int MATRIXSIZE_W = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step_i,
    input  logic [MATRIXSIZE_W-1:0] dim1_i,
    input  logic [MATRIXSIZE_W-1:0] dim2_i,
    output logic                    end_o
);
    localparam logic [MATRIXSIZE_W-1:0] ONE = MATRIXSIZE_W'(1);

    logic [MATRIXSIZE_W-1:0] row_q, row_d, col_q, col_d;
    logic                    row_end, col_end;

    // Compared against live dims: a mid-matrix change is not corrected.
    assign col_end = (col_q == dim2_i - ONE);
    assign row_end = (row_q == dim1_i - ONE);
    assign end_o   = row_end & col_end;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (step_i) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + ONE;
            end else begin
                col_d = col_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end
endmodule

// File: rtl/residual_add_ln_prep.sv
// residual_add_ln_prep
//   Joins the accumulator and residual streams element by element, rounds
//   and rescales, saturates to LN_BITS and emits the layer-norm input stream
//   with matrix-aligned tlast regenerated from DIM1/DIM2.
//   clk, rst  : clock, async active-high reset
//   s         : stream bundle (acc_*, res_* in; qout_* out)
//   DIM1/DIM2 : matrix rows / row length, must be stable per matrix
//   tlast_err : sticky, acc_tlast disagreed with the regenerated tlast
//   sat_cnt   : clipped-element count, present only with RESADD_SAT_CNT_EN
module residual_add_ln_prep
    import residual_add_ln_prep_pkg::*;
#(
    parameter int D_W          = D_W_DEF,
    parameter int D_W_ACC      = D_W_ACC_DEF,
    parameter int LN_BITS      = LN_BITS_DEF,
    parameter int ACC_SHIFT    = ACC_SHIFT_DEF,
    parameter int RES_SHIFT    = RES_SHIFT_DEF,
    parameter int MATRIXSIZE_W = MATRIXSIZE_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    residual_add_ln_prep_if.slave    s,
    input  logic [MATRIXSIZE_W-1:0]  DIM1,
    input  logic [MATRIXSIZE_W-1:0]  DIM2,
    output logic                     tlast_err
`ifdef RESADD_SAT_CNT_EN
    ,
    output logic [15:0]              sat_cnt
`endif
);
    localparam int SW = D_W_ACC + 2;
    localparam logic signed [D_W_ACC:0] RND = (D_W_ACC + 1)'(1) <<< (ACC_SHIFT - 1);

    logic [1:0]                vld_q;   // [0] stage 0, [1] output stage
    s0_pay_t                   pay0_q, pay0_d;
    logic signed [LN_BITS-1:0] q_q, q_d;
    logic                      lin1_q;
    logic                      tlast_err_q;
    logic                      dims_ok, en1, adv0, take, hs_out, pos_end;
    logic signed [D_W_ACC:0]   acc_ext, a_d, r_d;
    logic signed [SW-1:0]      sum;

    assign dims_ok = (DIM1 != '0) && (DIM2 != '0);
    assign en1     = s.qout_tready | ~vld_q[1];
    assign adv0    = en1 | ~vld_q[0];
    // Both streams are taken together or not at all.
    assign take    = s.acc_tvalid & s.res_tvalid & adv0 & dims_ok & ~rst;
    assign hs_out  = vld_q[1] & s.qout_tready;

    assign s.acc_tready  = take;
    assign s.res_tready  = take;
    assign s.qout_tvalid = vld_q[1];
    assign s.qout_tdata  = q_q;
    assign s.qout_tlast  = pos_end & vld_q[1];
    assign tlast_err     = tlast_err_q;

    always_comb begin
        acc_ext    = {s.acc_tdata[D_W_ACC-1], s.acc_tdata};
        // Round half up: bias by half an LSB before the arithmetic shift.
        a_d        = (acc_ext + RND) >>> ACC_SHIFT;
        r_d        = {{(D_W_ACC + 1 - D_W){s.res_tdata[D_W-1]}}, s.res_tdata} <<< RES_SHIFT;
        pay0_d     = '0;
        pay0_d.a   = a_d;
        pay0_d.r   = r_d;
        pay0_d.lin = s.acc_tlast;
        sum        = SW'(pay0_q.a) + SW'(pay0_q.r);
        q_d        = LN_BITS'(sat_to_ln(64'(sum), LN_BITS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= '0;
            pay0_q      <= '0;
            q_q         <= '0;
            lin1_q      <= 1'b0;
            tlast_err_q <= 1'b0;
        end else begin
            if (adv0) begin
                vld_q[0] <= take;
                if (take) pay0_q <= pay0_d;
            end
            // Output data only reloads when stage 0 holds an element, so it
            // stays stable while stalled.
            if (en1) begin
                vld_q[1] <= vld_q[0];
                if (vld_q[0]) begin
                    q_q    <= q_d;
                    lin1_q <= pay0_q.lin;
                end
            end
            if (hs_out && (lin1_q != s.qout_tlast)) tlast_err_q <= 1'b1;
        end
    end

    matrix_pos_counter #(
        .MATRIXSIZE_W(MATRIXSIZE_W)
    ) u_pos (
        .clk    (clk),
        .rst    (rst),
        .step_i (hs_out),
        .dim1_i (DIM1),
        .dim2_i (DIM2),
        .end_o  (pos_end)
    );

`ifdef RESADD_SAT_CNT_EN
    logic        clip_d, clip1_q;
    logic [15:0] sat_cnt_q;

    // Clipped iff the narrowed value no longer sign-extends back to the sum.
    assign clip_d  = (64'(q_d) != 64'(sum));
    assign sat_cnt = sat_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip1_q   <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            if (en1 && vld_q[0]) clip1_q <= clip_d;
            if (hs_out && clip1_q && (sat_cnt_q != 16'hFFFF)) sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_residual_add_ln_prep.sv
module tb_residual_add_ln_prep;
    import residual_add_ln_prep_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] dim1, dim2;
    logic        tlast_err;
`ifdef RESADD_SAT_CNT_EN
    logic [15:0] sat_cnt;
`endif

    residual_add_ln_prep_if #(.D_W(8), .D_W_ACC(32), .LN_BITS(22)) bus();

    residual_add_ln_prep dut (
        .clk       (clk),
        .rst       (rst),
        .s         (bus),
        .DIM1      (dim1),
        .DIM2      (dim2),
        .tlast_err (tlast_err)
`ifdef RESADD_SAT_CNT_EN
        ,
        .sat_cnt   (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [21:0] data; logic last; } exp_t;
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // 0: always ready, 1: stalled, 2: random 25% duty
    int   bp_mode  = 0;
    logic rnd_bit  = 1'b0;
    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) == 0);
    end
    assign bus.qout_tready = (bp_mode == 0) | ((bp_mode == 2) & rnd_bit);

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && bus.qout_tvalid && bus.qout_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=0x%0h required=none", bus.qout_tdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("qout_tdata", bus.qout_tdata, e.data);
                chk("qout_tlast", bus.qout_tlast, e.last);
            end
        end
    end

    function automatic logic [21:0] model(input logic [31:0] acc, input logic [7:0] res);
        longint a, s;
        a = (longint'($signed(acc)) + 128) >>> 8;
        s = a + longint'($signed(res)) * 64;
        if (s > 2097151) s = 2097151;
        else if (s < -2097152) s = -2097152;
        return s[21:0];
    endfunction

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input logic [31:0] acc, input logic [7:0] res, input logic last,
                        input logic [21:0] exp_d, input logic exp_l);
        int   n;
        logic hs;
        n  = 0;
        hs = 1'b0;
        bus.acc_tdata  = acc;
        bus.acc_tlast  = last;
        bus.res_tdata  = res;
        bus.acc_tvalid = 1'b1;
        bus.res_tvalid = 1'b1;
        while (!hs && n < 2000) begin
            @(negedge clk);
            hs = bus.acc_tready;
            if (hs) exp_q.push_back('{exp_d, exp_l});
            @(posedge clk);
            #1;
            n++;
        end
        bus.acc_tvalid = 1'b0;
        bus.res_tvalid = 1'b0;
        bus.acc_tlast  = 1'b0;
        if (!hs) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=no_handshake required=handshake");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] acc;
        logic [7:0]  res;
        int          n;

        rst = 1'b1;
        dim1 = 24'd2;
        dim2 = 24'd3;
        bus.acc_tdata  = '0;
        bus.acc_tlast  = 1'b0;
        bus.res_tdata  = '0;
        bus.acc_tvalid = 1'b1;   // readies must still stay low in reset
        bus.res_tvalid = 1'b1;
        #12;
        chk("rst_qout_tvalid", bus.qout_tvalid, 0);
        chk("rst_qout_tdata",  bus.qout_tdata, 0);
        chk("rst_qout_tlast",  bus.qout_tlast, 0);
        chk("rst_tlast_err",   tlast_err, 0);
        chk("rst_acc_tready",  bus.acc_tready, 0);
        chk("rst_res_tready",  bus.res_tready, 0);
        bus.acc_tvalid = 1'b0;
        bus.res_tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Matrix A (2x3), correctly framed; first element also checks latency.
        send(32'h0000_0180, 8'd3, 1'b0, 22'd194, 1'b0);
        @(negedge clk);
        chk("lat_valid_cycle1", bus.qout_tvalid, 0);
        @(negedge clk);
        chk("lat_valid_cycle2", bus.qout_tvalid, 1);
        chk("lat_data_cycle2",  bus.qout_tdata, 194);
        @(posedge clk);
        #1;
        send(32'h7FFF_FFFF, 8'h7F, 1'b0, 22'h1F_FFFF, 1'b0);
        send(32'h8000_0000, 8'h80, 1'b0, 22'h20_0000, 1'b0);
        send(32'h0000_007F, 8'h00, 1'b0, 22'd0,       1'b0);
        send(32'h0000_0080, 8'h00, 1'b0, 22'd1,       1'b0);
        send(32'hFFFF_FF80, 8'hFF, 1'b1, 22'h3F_FFC0, 1'b1);
        drain();
        chk("framed_tlast_err", tlast_err, 0);
`ifdef RESADD_SAT_CNT_EN
        chk("sat_cnt_after_A", sat_cnt, 2);
`endif

        // Matrix B, acc_tlast on the 5th element.
        send(32'h1FFF_FF00, 8'h00, 1'b0, 22'h1F_FFFF, 1'b0);
        send(32'h1FFF_FF80, 8'h00, 1'b0, 22'h1F_FFFF, 1'b0);
        send(32'hFFFF_FE00, 8'h01, 1'b0, 22'd62,      1'b0);
        send(32'h0000_0100, 8'hFE, 1'b0, 22'h3F_FF81, 1'b0);
        send(32'h0000_0000, 8'h05, 1'b1, 22'd320,     1'b0);
        send(32'h1234_5678, 8'h10, 1'b0, 22'h12_3856, 1'b1);
        drain();
        chk("misframed_tlast_err", tlast_err, 1);

        // Stream skew: residual lags accumulator by 5 cycles.
        bus.acc_tdata  = 32'h0000_0280;
        bus.res_tdata  = 8'hFF;
        bus.acc_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("skew_acc_tready", bus.acc_tready, 0);
            chk("skew_res_tready", bus.res_tready, 0);
            @(posedge clk);
            #1;
        end
        send(32'h0000_0280, 8'hFF, 1'b0, 22'h3F_FFC3, 1'b0);
        drain();

        // Stall: two elements buffered, then the readies drop.
        bp_mode = 1;
        send(32'h0000_0400, 8'h02, 1'b0, 22'd132,     1'b0);
        send(32'hFFFF_FF00, 8'h00, 1'b0, 22'h3F_FFFF, 1'b0);
        bus.acc_tdata  = 32'h0000_7FFF;
        bus.res_tdata  = 8'h40;
        bus.acc_tvalid = 1'b1;
        bus.res_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_acc_tready", bus.acc_tready, 0);
            chk("stall_qout_tvalid", bus.qout_tvalid, 1);
            chk("stall_qout_tdata_held", bus.qout_tdata, 132);
            @(posedge clk);
            #1;
        end
        bp_mode = 0;
        send(32'h0000_7FFF, 8'h40, 1'b0, 22'h00_1080, 1'b0);
        send(32'hFFFF_FF7F, 8'h00, 1'b0, 22'h3F_FFFF, 1'b0);
        send(32'h0001_0000, 8'h81, 1'b1, 22'h3F_E140, 1'b1);
        drain();
        chk("tlast_err_sticky", tlast_err, 1);

        // Random backpressure over a 768x4 matrix.
        dim1 = 24'd768;
        dim2 = 24'd4;
        bp_mode = 2;
        for (int i = 0; i < 3072; i++) begin
            acc = $urandom;
            res = 8'($urandom);
            if (i % 2 == 1) acc = {{16{acc[15]}}, acc[15:0]};
            send(acc, res, (i == 3071), model(acc, res), (i == 3071));
        end
        drain();
        bp_mode = 0;

        // Async reset mid-matrix with an element held at the output.
        dim1 = 24'd2;
        dim2 = 24'd3;
        send(32'h0000_0100, 8'h00, 1'b0, 22'd1, 1'b0);
        drain();
        bp_mode = 1;
        send(32'h0000_0200, 8'h00, 1'b0, 22'd2, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.qout_tvalid && n < 20);
        chk("pre_reset_qout_tvalid", bus.qout_tvalid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_qout_tvalid", bus.qout_tvalid, 0);
        chk("async_rst_tlast_err", tlast_err, 0);
        exp_q.delete();
        bp_mode = 0;
        @(negedge clk);
        rst = 1'b0;
        dim1 = 24'd1;
        dim2 = 24'd2;
        @(posedge clk);
        #1;
        send(32'h0000_0300, 8'h00, 1'b0, 22'd3, 1'b0);
        send(32'h0000_0400, 8'h00, 1'b1, 22'd4, 1'b1);
        drain();
        chk("post_rst_tlast_err", tlast_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/residual_add_ln_prep.md
# residual_add_ln_prep

Stage directly upstream of the layer-norm stage. It joins the 32-bit matmul accumulator stream with the 8-bit residual (skip-connection) stream element by element. Each sum is rescaled and rounded, then saturated to LN_BITS, and the result is emitted as the `qin` AXI-Stream the layer-norm stage consumes. It also regenerates matrix-aligned `tlast` from DIM1/DIM2 and flags framing mismatches.

## Interface
Parameters:
- `D_W`, 8, residual element width (signed)
- `D_W_ACC`, 32, accumulator element width (signed)
- `LN_BITS`, 22, output element width (signed)
- `ACC_SHIFT`, 8, arithmetic right shift applied to the accumulator (≥1)
- `RES_SHIFT`, 6, left shift applied to the residual
- `MATRIXSIZE_W`, 24, width of the DIM1/DIM2 inputs and of the internal counters

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  reset; asynchronous, active-high
- `acc_tdata`  in  D_W_ACC  accumulator element
- `acc_tlast`  in  1  accumulator end-of-matrix marker
- `acc_tvalid`  in  1  accumulator valid
- `acc_tready`  out  1  accumulator ready
- `res_tdata`  in  D_W  residual element
- `res_tvalid`  in  1  residual valid
- `res_tready`  out  1  residual ready
- `qout_tdata`  out  LN_BITS  saturated sum (feeds layer-norm `qin`)
- `qout_tlast`  out  1  asserted on the last element of the matrix
- `qout_tvalid`  out  1  output valid
- `qout_tready`  in  1  output ready
- `DIM1`  in  MATRIXSIZE_W  rows
- `DIM2`  in  MATRIXSIZE_W  columns (row length)
- `tlast_err`  out  1  sticky framing error

## Operation
- **Join rule**
  - `acc_tready = res_tready = acc_tvalid & res_tvalid & adv0 & dims_ok`.
  - `adv0` is the stage-0 advance condition.
  - `dims_ok = (DIM1!=0) & (DIM2!=0)`.
  - Both streams are consumed in the same cycle; an element is never taken from only one of them.
- **Stage 0 register** captures:
  - `a_r = (acc + 2^(ACC_SHIFT-1)) >>> ACC_SHIFT`, computed in D_W_ACC+1 bits (round half up).
  - `r_r = sext(res) <<< RES_SHIFT`.
  - `acc_tlast`, captured as `lin_r`.
- **Stage 1 register** computes:
  - `s = a_r + r_r` in D_W_ACC+2 bits.
  - `s` is saturated to `[-2^(LN_BITS-1), 2^(LN_BITS-1)-1]` and drives `qout_tdata`.
- **Pipeline control**
  - `en1 = qout_tready | ~qout_tvalid`.
  - `adv0 = en1 | ~v0`.
  - Each stage's valid bit moves forward when its enable is high; a bubble is squeezed out.
- **Counters**
  - `col` runs 0..DIM2-1 and `row` runs 0..DIM1-1.
  - Both advance on the output handshake; `col` wraps to 0 and `row` increments; at (DIM1-1, DIM2-1) both wrap to 0.
  - `qout_tlast = (row==DIM1-1) & (col==DIM2-1) & qout_tvalid`.
- **Framing check**
  - On each output handshake, compare the carried `lin` bit against `qout_tlast`.
  - On mismatch, set `tlast_err`; it stays set until `rst`.
  - Data flow continues regardless of `tlast_err`.
- **Dimension changes**
  - DIM1/DIM2 must stay stable while a matrix is in flight.
  - Counters compare against the live values; a change mid-matrix is not corrected.

## Timing
- Reset values: `qout_tvalid=0`, `qout_tdata=0`, `qout_tlast=0`, `tlast_err=0`. All counters and valid bits are 0 and `acc_tready`/`res_tready` are 0.
- Latency: 2 cycles from the joint input handshake to `qout_tvalid` when unstalled.
- Throughput: 1 element/cycle while `qout_tready=1`.
- Stall: with `qout_tready=0` the pipeline holds up to 2 elements, then `acc_tready`/`res_tready` drop.
  - `qout_tdata` is held stable while `qout_tvalid & ~qout_tready`.
- Simultaneous input accept and output handshake in the same cycle is supported with no bubble.
- Reset asserted mid-matrix: valid bits, counters and `tlast_err` clear immediately (asynchronous); in-flight data is dropped.

## Configuration
- **`RESADD_SAT_CNT_EN`**
  - Defined: adds output `sat_cnt` [15:0], which counts output handshakes whose element was clipped. It saturates at 0xFFFF and resets to 0.
  - Undefined: the port and its logic are absent; saturation behaviour is unchanged.

## Structure
- The shared package holds:
  - the default values of `ACC_SHIFT`, `RES_SHIFT` and `LN_BITS`;
  - `sat_to_ln` as a function that saturates D_W_ACC+2 bits down to LN_BITS;
  - a packed typedef for the stage-0 payload {a, r, lin}.
- Sub-module `matrix_pos_counter` holds the row/col counters and end-of-matrix detect. It is reused on the layer-norm output side.

## Test plan
- **Basic arithmetic:** acc=0x00000180, res=3, shifts 8/6 → (384+128)>>8 = 2 (round half up), plus 3<<6=192, so qout=194, valid 2 cycles after the handshake.
- **Saturation:**
  - acc=0x7FFFFFFF, res=127 → qout=0x1FFFFF.
  - acc=0x80000000, res=-128 → qout=-0x200000.
  - With `RESADD_SAT_CNT_EN` defined, `sat_cnt` increments by 2.
- **Framing:**
  - DIM1=2, DIM2=3 with 6 elements and acc_tlast on the 6th → qout_tlast only on element 6; counters return to (0,0); `tlast_err` stays 0.
  - Moving acc_tlast to the 5th element sets `tlast_err`.
- **Backpressure:**
  - Random `qout_tready` with 25% duty over 768×4 elements → output order and values match the model, no loss or duplication.
  - `acc_tready` low after 2 elements are buffered.
- **Stream skew:** res_tvalid lags acc_tvalid by 5 cycles → no element consumed until both are valid; both readies assert together.
- **Reset:** async `rst` pulse mid-matrix with `qout_tvalid=1` → `qout_tvalid` drops without a clock edge; the next matrix starts at row 0, col 0.
